// File: rtl/seq_shift_add_mult_if.sv
// Operand/result bundle for the sequential shift-and-add multiplier.
// The requester drives start and the operands; the multiplier returns busy, done and product.
interface seq_shift_add_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier, one partial product per clock.
// Signed mode folds the multiplier's sign bit in by subtracting the last partial product,
// so the 2*WIDTH accumulator always holds the exact two's complement result.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// RUN   | one iteration per cycle, counter 0..WIDTH-1
// FIN   | accumulator copied to product, done pulses on the following cycle
module seq_shift_add_mult #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  seq_shift_add_mult_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   mcand_q;   // extended multiplicand, pre-shifted by the iteration index
  logic [WIDTH-1:0]     mplier_q;  // multiplier, shifted right so bit 0 is the current bit
  logic                 sm_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 last_iter;

  assign last_iter   = (cnt_q == LAST);
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.product = product_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulate/shift per iteration, result and done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      sm_q      <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= (state_q == FIN);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q  <= {{WIDTH{bus.signed_mode & bus.a[WIDTH-1]}}, bus.a};
            mplier_q <= bus.b;
            sm_q     <= bus.signed_mode;
            acc_q    <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          if (mplier_q[0]) begin
            // the multiplier's sign bit carries weight -2^(WIDTH-1)
            if (sm_q && last_iter) acc_q <= acc_q - mcand_q;
            else                   acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        FIN: product_q <= acc_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: an 8-bit instance driven from a vector table plus
// hand sequences for restart/abort behaviour, and an exhaustive 4-bit instance.
module tb_seq_shift_add_mult;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_shift_add_mult_if #(.WIDTH(8)) bus8();
  seq_shift_add_mult_if #(.WIDTH(4)) bus4();

  seq_shift_add_mult #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_shift_add_mult #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one 8-bit op from an idle DUT; returns product at done and cycles from accept to done.
  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    bus8.signed_mode = sm;
    bus8.a = a;
    bus8.b = b;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    lat = 0;
    while (!bus8.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus8.product;
  endtask

  task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] p, output int lat);
    bus4.signed_mode = sm;
    bus4.a = a;
    bus4.b = b;
    bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    lat = 0;
    while (!bus4.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = bus4.product;
  endtask

  initial begin
    logic [15:0] p16;
    logic [15:0] prev;
    logic [7:0]  p8;
    logic [7:0]  e8;
    int          lat;
    int          n;
    int          ndone;
    int          av;
    int          bv;
    logic        hold_bad;

    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 8'h0F, 8'h0F, 16'h00E1};
    vecs[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[3]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[4]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[5]  = '{1'b0, 8'h12, 8'h34, 16'h03A8};
    vecs[6]  = '{1'b0, 8'h00, 8'hFF, 16'h0000};
    vecs[7]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    vecs[8]  = '{1'b1, 8'h03, 8'hFB, 16'hFFF1};
    vecs[9]  = '{1'b0, 8'hFB, 8'hFB, 16'hF619};
    vecs[10] = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[11] = '{1'b0, 8'h80, 8'h7F, 16'h3F80};

    rst = 1'b1;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", bus8.busy, 0);
    check("reset_done", bus8.done, 0);
    check("reset_product", bus8.product, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven operations
    for (int i = 0; i < 12; i++) begin
      run8(vecs[i].sm, vecs[i].a, vecs[i].b, p16, lat);
      check($sformatf("vec%0d_product", i), p16, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_at_done", i), bus8.busy, 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_one_cycle", i), bus8.done, 0);
      check($sformatf("vec%0d_product_hold", i), bus8.product, vecs[i].exp);
    end

    // Start re-pulsed with fresh operands on every busy cycle
    prev = bus8.product;
    hold_bad = 1'b0;
    bus8.signed_mode = 1'b0;
    bus8.a = 8'h03;
    bus8.b = 8'h05;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    ndone = 0;
    p16 = '0;
    while (n < 40 && ndone == 0) begin
      if (bus8.done) begin
        ndone++;
        p16 = bus8.product;
      end else if (bus8.product !== prev) begin
        hold_bad = 1'b1;
      end
      if (bus8.busy) begin
        bus8.start = 1'b1;
        bus8.a = 8'(n + 9);
        bus8.b = 8'(n * 3 + 1);
      end else begin
        bus8.start = 1'b0;
      end
      if (ndone == 0) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("repulse_done_seen", ndone, 1);
    check("repulse_product", p16, 16'h000F);
    check("repulse_latency", n, 9);
    check("repulse_no_partial_sums", hold_bad, 0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus8.done || bus8.busy) ndone++;
    end
    check("repulse_no_second_op", ndone, 0);
    run8(1'b0, 8'h0F, 8'h0F, p16, lat);
    check("after_repulse_product", p16, 16'h00E1);
    check("after_repulse_latency", lat, 9);
    @(posedge clk); #1;

    // Reset four cycles into an operation aborts it without a done pulse
    bus8.signed_mode = 1'b0;
    bus8.a = 8'h12;
    bus8.b = 8'h34;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before_rst", bus8.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", bus8.busy, 0);
    check("abort_done", bus8.done, 0);
    check("abort_product", bus8.product, 0);
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus8.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_product_held", bus8.product, 0);
    run8(1'b0, 8'h12, 8'h34, p16, lat);
    check("post_abort_product", p16, 16'h03A8);
    check("post_abort_latency", lat, 9);
    @(posedge clk); #1;

    // Exhaustive 4-bit, unsigned then signed
    for (int sm = 0; sm < 2; sm++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          av = (sm == 1 && a >= 8) ? a - 16 : a;
          bv = (sm == 1 && b >= 8) ? b - 16 : b;
          e8 = 8'(av * bv);
          run4(sm[0], a[3:0], b[3:0], p8, lat);
          check($sformatf("w4_s%0d_%0d_%0d_product", sm, a, b), p8, e8);
          check($sformatf("w4_s%0d_%0d_%0d_latency", sm, a, b), lat, 5);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
